ps2_receiver: RTL
=================

# ps2_receiver

Deserializes the PS/2 keyboard line (ps2_clk / ps2_data) into validated scancode bytes. Strips the 0xE0 (extended) and 0xF0 (release) prefixes and presents them as flags alongside the final code byte. Sits between the keyboard pins and the message decoder, which consumes `scancode`, `scancode_valid`, `release_key` and `extended_code`.

## Interface

- `SYNC_STAGES`, 2: flip-flops in each pin synchronizer (≥2).
- `TIMEOUT_CYCLES`, 2000: clk cycles allowed between ps2_clk falling edges inside a frame before abort.

- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `ps2_clk`  in  1  raw keyboard clock pin (asynchronous).
- `ps2_data`  in  1  raw keyboard data pin (asynchronous).
- `scancode`  out  8  last non-prefix code byte.
- `scancode_valid`  out  1  one-cycle pulse: `scancode` and flags are valid.
- `release_key`  out  1  0xF0 received since the last code byte.
- `extended_code`  out  1  0xE0 received since the last code byte.
- `frame_error`  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation

- Both pins pass through `SYNC_STAGES` flops. A falling edge (`fall`) is previous-synced-clk=1 and current=0.
- The frame is 11 bits, one per `fall`:
  - start bit = 0;
  - 8 data bits, LSB first;
  - odd parity over data+parity;
  - stop bit = 1.
- FSM states:
  - IDLE: on `fall` with data=0 → DATA, bit_cnt=0. On `fall` with data=1, stay in IDLE (noise); no error.
  - DATA: on `fall`, shift the bit into shreg[bit_cnt]. When bit_cnt=7 → PARITY, else bit_cnt+1.
  - PARITY: on `fall`, latch parity_ok = ^{shreg,bit}. → STOP.
  - STOP: on `fall`, if bit=1 and parity_ok → deliver byte; else pulse `frame_error`. → IDLE in both cases.
- Byte delivery:
  - 0xE0: set ext flag. No valid pulse.
  - 0xF0: set rel flag. No valid pulse.
  - Any other value: `scancode`<=byte, pulse `scancode_valid`. `extended_code`/`release_key` show the flags during that pulse. Both flags clear on the following cycle.
- Flags are sticky and order-independent: E0 F0 xx gives both set.
- Timeout: a counter resets on every `fall` and counts while state≠IDLE. Reaching `TIMEOUT_CYCLES` → IDLE, pulse `frame_error`, discard partial byte.
- Any `frame_error` also clears the ext/rel flags.
- Reset values: state IDLE, `scancode`=0x00, `scancode_valid`=0, `release_key`=0, `extended_code`=0, `frame_error`=0, counters 0, synchronizers reset to 1 (idle line). Reset mid-frame discards everything.
- No back-pressure. `scancode` holds its value until the next delivery.

## Timing

- All outputs are registered.
- The `fall` pulse appears `SYNC_STAGES` clk edges after the pin transition. The FSM acts on the next edge.
- `scancode_valid` / `frame_error` rise `SYNC_STAGES`+1 clk edges after the stop-bit ps2_clk falling edge. Each is high for exactly 1 cycle.
- `release_key`/`extended_code`:
  - rise SYNC_STAGES+1 edges after the prefix's stop-bit fall;
  - stay high through the valid cycle;
  - are low on the cycle after it.
- `scancode_valid` and `frame_error` are never high together.
- Timeout abort occurs `TIMEOUT_CYCLES` cycles after the last `fall`.

## Structure

- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_REL=8'hF0.
- Sub-module `ps2_sync`: parameterized synchronizer plus falling-edge detector. Outputs synced data and the `fall` pulse. Instantiated once for the clk/data pair.
- The FSM, timeout counter and prefix flags are in `ps2_receiver`.

## Test plan

- Frame 0x1C (bits 0,00111000,0,1) → one `scancode_valid` with `scancode`=0x1C, `release_key`=0, `extended_code`=0.
- F0 then 1C → exactly one valid pulse, `scancode`=0x1C, `release_key`=1, `extended_code`=0. Both flags are 0 on the next cycle.
- E0 F0 14 → one valid pulse, `scancode`=0x14, both flags 1. No pulse for the prefix bytes.
- 0x1C with parity bit flipped → `frame_error` pulse, no valid pulse, `scancode` unchanged. F0 then bad-parity frame then 1C → `release_key`=0 on the 1C pulse.
- Stop after 4 data bits for `TIMEOUT_CYCLES`+10 cycles → `frame_error` at timeout. A following clean 0x29 frame → valid with 0x29.
- Assert `rst_n`=0 mid-frame after E0 received → all outputs 0 immediately. A following clean 0x5A frame → `scancode`=0x5A with `extended_code`=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

endpackage

// File: rtl/ps2_sync.sv
// Pin synchronizer for the PS/2 clock/data pair plus ps2_clk falling-edge detect.
// Both chains reset to 1 so an idle line produces no spurious edge.
module ps2_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sync_data,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_prev;

    // Shift both pins through the synchronizer chains and remember the last synced clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign sync_data = data_sr[SYNC_STAGES-1];
    assign fall      = clk_prev & ~clk_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: deserializes 11-bit frames, checks parity/stop,
// strips E0/F0 prefixes into sticky flags and aborts stalled frames on timeout.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       release_key,
    output logic       extended_code,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          sync_data;
    logic          fall;

    ps2_state_t    state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          parity_ok, parity_ok_n;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    scancode_n;
    logic          valid_n, error_n, rel_n, ext_n;

    ps2_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sync_data(sync_data),
        .fall     (fall)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            parity_ok      <= 1'b0;
            timer          <= '0;
            scancode       <= '0;
            scancode_valid <= 1'b0;
            frame_error    <= 1'b0;
            release_key    <= 1'b0;
            extended_code  <= 1'b0;
        end else begin
            state          <= state_n;
            bit_cnt        <= bit_cnt_n;
            shreg          <= shreg_n;
            parity_ok      <= parity_ok_n;
            timer          <= timer_n;
            scancode       <= scancode_n;
            scancode_valid <= valid_n;
            frame_error    <= error_n;
            release_key    <= rel_n;
            extended_code  <= ext_n;
        end
    end

    // Next-state, frame assembly, prefix flag and timeout logic.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        parity_ok_n = parity_ok;
        scancode_n  = scancode;
        valid_n     = 1'b0;
        error_n     = 1'b0;
        rel_n       = release_key;
        ext_n       = extended_code;

        // Flags were shown alongside the code byte; drop them one cycle later.
        if (scancode_valid) begin
            rel_n = 1'b0;
            ext_n = 1'b0;
        end

        if (fall || state == IDLE) begin
            timer_n = '0;
        end else begin
            timer_n = timer + 1'b1;
        end

        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!sync_data) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n[bit_cnt] = sync_data;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    parity_ok_n = ^{shreg, sync_data};
                    state_n     = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (sync_data && parity_ok) begin
                        if (shreg == PS2_PREFIX_EXT) begin
                            ext_n = 1'b1;
                        end else if (shreg == PS2_PREFIX_REL) begin
                            rel_n = 1'b1;
                        end else begin
                            scancode_n = shreg;
                            valid_n    = 1'b1;
                        end
                    end else begin
                        error_n = 1'b1;
                        rel_n   = 1'b0;
                        ext_n   = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            timer_n = '0;
            error_n = 1'b1;
            rel_n   = 1'b0;
            ext_n   = 1'b0;
        end
    end

endmodule
